// File: rtl/isa_io_cycle_engine.sv
// ---------------------------------------------------------------------------
// isa_io_cycle_engine
//
// ISA I/O bus master. Each accepted request becomes one fully timed ISA I/O
// cycle: address setup, IOR#/IOW# strobe, optional IOCHRDY wait states,
// hold, then recovery before the next request can be accepted.
//
// Optional feature macro: ISA_IOCHRDY_EN
//   defined   -> IOCHRDY wait states with a bounded READY_TIMEOUT abort
//   undefined -> iochrdy is ignored and the cycle length is fixed
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only in IDLE. req_valid seen while
// req_ready is 0 is ignored, not queued. rsp_valid is a one-cycle pulse
// with no back-pressure. rsp_timeout qualifies it.
//
// Ports:
//   bus_clock, reset          clock and synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_write, req_byte       direction and 8-bit access select
//   req_address, req_data     I/O port address and write data
//   rsp_valid, rsp_data       completion pulse and read data
//   rsp_timeout               completion was an IOCHRDY timeout abort
//   bus_address, aen, sbhe_n  ISA address phase outputs
//   bus_data_out/oe/in        data pad tristate interface
//   ior_n, iow_n              active-low I/O strobes
//   iochrdy                   device ready input
//   dbg_state                 current FSM state, for debug visibility
// ---------------------------------------------------------------------------
module isa_io_cycle_engine #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 16,
    parameter int SETUP_CYCLES    = 2,
    parameter int STROBE_CYCLES   = 3,
    parameter int HOLD_CYCLES     = 1,
    parameter int RECOVERY_CYCLES = 2,
    parameter int READY_TIMEOUT   = 64
) (
    input  logic                  bus_clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_byte,
    input  logic [ADDR_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  bus_data_oe,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic                  ior_n,
    output logic                  iow_n,
    output logic                  sbhe_n,
    output logic                  aen,
    input  logic                  iochrdy,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_STROBE  = 3'd2,
        S_WAIT    = 3'd3,
        S_HOLD    = 3'd4,
        S_RECOVER = 3'd5
    } state_t;

    localparam logic [15:0] SETUP_LAST   = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] STROBE_LAST  = 16'(STROBE_CYCLES - 1);
    localparam logic [15:0] HOLD_LAST    = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] RECOVER_LAST = 16'(RECOVERY_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] LOW_MASK = DATA_WIDTH'(8'hFF);
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;

    state_t                r_state, w_state_next;
    logic [15:0]           r_cnt, w_cnt_next;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_next;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_next;
    logic                  r_write, w_write_next;
    logic                  r_byte, w_byte_next;

    logic                  r_ready, r_rsp_valid, r_rsp_timeout;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_oe, r_ior_n, r_iow_n, r_sbhe_n, r_aen;

    logic                  w_req_byte;
    logic                  w_done, w_timeout;
    logic                  w_active_next, w_strobe_next;
    logic [DATA_WIDTH-1:0] w_rd_data;

`ifdef ISA_IOCHRDY_EN
    localparam int WCNT_W = $clog2(READY_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] TIMEOUT_LAST = WCNT_W'(READY_TIMEOUT - 1);
    logic [WCNT_W-1:0] r_wcnt, w_wcnt_next;
`else
    localparam int UNUSED_TIMEOUT = READY_TIMEOUT;
    logic w_unused_iochrdy;
    assign w_unused_iochrdy = iochrdy;
`endif

    // An 8-bit bus has no high byte lane, so every access is a byte access.
    assign w_req_byte = (DATA_WIDTH == 8) ? 1'b1 : req_byte;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_write_next = r_write;
        w_byte_next  = r_byte;
        w_done       = 1'b0;
        w_timeout    = 1'b0;
`ifdef ISA_IOCHRDY_EN
        w_wcnt_next  = r_wcnt;
`endif
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (req_valid) begin
                    w_state_next = S_SETUP;
                    w_addr_next  = req_address;
                    w_write_next = req_write;
                    w_byte_next  = w_req_byte;
                    // Byte writes drive the unused upper lane as zero.
                    w_wdata_next = req_write ? (req_data & (w_req_byte ? LOW_MASK : ALL_ONES))
                                             : '0;
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_next = S_STROBE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_STROBE: begin
                if (r_cnt == STROBE_LAST) begin
                    w_cnt_next = '0;
`ifdef ISA_IOCHRDY_EN
                    if (iochrdy) begin
                        w_state_next = S_HOLD;
                        w_done       = 1'b1;
                    end else begin
                        w_state_next = S_WAIT;
                        w_wcnt_next  = '0;
                    end
`else
                    w_state_next = S_HOLD;
                    w_done       = 1'b1;
`endif
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_WAIT: begin
`ifdef ISA_IOCHRDY_EN
                if (iochrdy) begin
                    w_state_next = S_HOLD;
                    w_done       = 1'b1;
                end else if (r_wcnt == TIMEOUT_LAST) begin
                    // READY_TIMEOUT wait cycles have elapsed with the device still busy.
                    w_state_next = S_HOLD;
                    w_done       = 1'b1;
                    w_timeout    = 1'b1;
                end else begin
                    w_wcnt_next = r_wcnt + 1'b1;
                end
`else
                // Unreachable without wait-state support; release the bus safely.
                w_state_next = S_RECOVER;
                w_cnt_next   = '0;
`endif
            end
            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_next = S_RECOVER;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            S_RECOVER: begin
                if (r_cnt == RECOVER_LAST) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Bus pins are registered from the next state so they never glitch.
    assign w_active_next = (w_state_next == S_SETUP) || (w_state_next == S_STROBE) ||
                           (w_state_next == S_WAIT)  || (w_state_next == S_HOLD);
    assign w_strobe_next = (w_state_next == S_STROBE) || (w_state_next == S_WAIT);

    // Timed-out reads return all ones; byte reads clear the upper lane either way.
    assign w_rd_data = (w_timeout ? ALL_ONES : bus_data_in) & (r_byte ? LOW_MASK : ALL_ONES);

    always_ff @(posedge bus_clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_write       <= 1'b0;
            r_byte        <= 1'b1;
            r_ready       <= 1'b1;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_rsp_data    <= '0;
            r_oe          <= 1'b0;
            r_ior_n       <= 1'b1;
            r_iow_n       <= 1'b1;
            r_sbhe_n      <= 1'b1;
            r_aen         <= 1'b1;
`ifdef ISA_IOCHRDY_EN
            r_wcnt        <= '0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_addr        <= w_addr_next;
            r_wdata       <= w_wdata_next;
            r_write       <= w_write_next;
            r_byte        <= w_byte_next;
            r_ready       <= (w_state_next == S_IDLE);
            r_rsp_valid   <= w_done;
            r_rsp_timeout <= w_timeout;
            if (w_done && !r_write) begin
                r_rsp_data <= w_rd_data;
            end
            r_oe          <= w_active_next && w_write_next;
            r_ior_n       <= !(w_strobe_next && !w_write_next);
            r_iow_n       <= !(w_strobe_next && w_write_next);
            r_sbhe_n      <= !(w_active_next && !w_byte_next);
            r_aen         <= !w_active_next;
`ifdef ISA_IOCHRDY_EN
            r_wcnt        <= w_wcnt_next;
`endif
        end
    end

    assign req_ready    = r_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_timeout  = r_rsp_timeout;
    assign rsp_data     = r_rsp_data;
    assign bus_address  = r_addr;
    assign bus_data_out = r_wdata;
    assign bus_data_oe  = r_oe;
    assign ior_n        = r_ior_n;
    assign iow_n        = r_iow_n;
    assign sbhe_n       = r_sbhe_n;
    assign aen          = r_aen;
    assign dbg_state    = r_state;

endmodule
